pifo_calendar_ctrl: RTL

- Front-end controller for the root PIFO calendar atom chain.
- Accepts rank/info insert requests and dequeue requests over valid/ready handshakes, then packs elements into the chain format (valid bit, rank field, info field).
- Drives the broadcast element and insert/pop controls to every atom, and tracks occupancy.
- Captures the head atom's element into a registered dequeue output.

---
 rtl/pifo_calendar_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/pifo_calendar_ctrl.sv
// Front-end controller for the root PIFO calendar atom chain: packs and issues inserts/pops,
// tracks occupancy and captures the head element. Optional feature macro: PIFO_OVERWRITE_EN.
module pifo_calendar_ctrl #(
   parameter int ELEMENT_WIDTH       = 32,
   parameter int ELEMENT_RANK_WIDTH  = 19,
   parameter int RANK_START_POS      = 12,
   parameter int RANK_END_POS        = 30,
   parameter int PIFO_INFO_VALID_POS = 31,
   parameter int INFO_WIDTH          = 12,
   parameter int PIFO_DEPTH          = 16,
   parameter int COUNT_WIDTH         = 5
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          s_ins_valid,
   output logic                          s_ins_ready,
   input  logic [ELEMENT_RANK_WIDTH-1:0] s_ins_rank,
   input  logic [INFO_WIDTH-1:0]         s_ins_info,
   input  logic                          s_pop_valid,
   output logic                          s_pop_ready,
   output logic                          m_deq_valid,
   input  logic                          m_deq_ready,
   output logic [ELEMENT_RANK_WIDTH-1:0] m_deq_rank,
   output logic [INFO_WIDTH-1:0]         m_deq_info,
   output logic [ELEMENT_WIDTH-1:0]      out_pifo_input,
   output logic                          out_ctl_insert,
   output logic                          out_ctl_pop,
   input  logic [ELEMENT_WIDTH-1:0]      in_pifo_head_element,
   input  logic [ELEMENT_WIDTH-1:0]      in_pifo_tail_element,
   output logic [COUNT_WIDTH-1:0]        out_count,
   output logic                          out_full,
   output logic                          out_empty
`ifdef PIFO_OVERWRITE_EN
   ,
   output logic [15:0]                   out_drop_count
`endif
);

   localparam logic [COUNT_WIDTH-1:0] DEPTH_C = COUNT_WIDTH'(PIFO_DEPTH);
   localparam logic [COUNT_WIDTH-1:0] ONE_C   = COUNT_WIDTH'(1);
   localparam logic [COUNT_WIDTH-1:0] ZERO_C  = COUNT_WIDTH'(0);

   function automatic logic [ELEMENT_WIDTH-1:0] pack_element(
      input logic [ELEMENT_RANK_WIDTH-1:0] rank,
      input logic [INFO_WIDTH-1:0]         info
   );
      logic [ELEMENT_WIDTH-1:0] elem;
      elem                               = '0;
      elem[PIFO_INFO_VALID_POS]          = 1'b1;
      elem[RANK_END_POS:RANK_START_POS]  = rank;
      elem[INFO_WIDTH-1:0]               = info;
      return elem;
   endfunction

   logic                          ins_acc_s;
   logic                          pop_acc_s;
   logic                          ins_issue_s;
   logic                          cnt_inc_s;
   logic [ELEMENT_RANK_WIDTH-1:0] ins_rank_s;
   logic [INFO_WIDTH-1:0]         ins_info_s;
   logic [COUNT_WIDTH-1:0]        cnt_nxt_s;
   logic                          unused_s;

   // Valid bit of the head and any bits outside rank/info carry nothing the controller needs.
   assign unused_s = ^{in_pifo_head_element, in_pifo_tail_element};

   assign s_pop_ready = ~out_empty & ~out_ctl_pop & ~m_deq_valid;
   assign pop_acc_s   = s_pop_valid & s_pop_ready;

`ifdef PIFO_OVERWRITE_EN
   // A full-chain insert arriving while another insert is in flight is parked for one cycle so
   // the tail compare sees the settled chain; s_ins_ready drops only during that one cycle.
   logic                          pend_valid_r;
   logic [ELEMENT_RANK_WIDTH-1:0] pend_rank_r;
   logic [INFO_WIDTH-1:0]         pend_info_r;
   logic                          cand_valid_s;
   logic                          defer_s;
   logic                          drop_evt_s;
   logic [ELEMENT_RANK_WIDTH-1:0] tail_rank_s;

   assign s_ins_ready  = ~pend_valid_r;
   assign ins_acc_s    = s_ins_valid & s_ins_ready;
   assign cand_valid_s = pend_valid_r | ins_acc_s;
   assign ins_rank_s   = pend_valid_r ? pend_rank_r : s_ins_rank;
   assign ins_info_s   = pend_valid_r ? pend_info_r : s_ins_info;
   assign tail_rank_s  = in_pifo_tail_element[RANK_END_POS:RANK_START_POS];

   // Insert decision: normal issue when room exists, otherwise defer or compare against the tail.
   always_comb begin
      ins_issue_s = 1'b0;
      cnt_inc_s   = 1'b0;
      defer_s     = 1'b0;
      drop_evt_s  = 1'b0;
      if (!cand_valid_s) begin
         ins_issue_s = 1'b0;
      end else if (!out_full || pop_acc_s) begin
         ins_issue_s = 1'b1;
         cnt_inc_s   = 1'b1;
      end else if (out_ctl_insert) begin
         defer_s = 1'b1;
      end else begin
         drop_evt_s  = 1'b1;
         ins_issue_s = (ins_rank_s < tail_rank_s);
      end
   end

   // Parked full-chain insert awaiting a settled tail.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pend_valid_r <= 1'b0;
         pend_rank_r  <= '0;
         pend_info_r  <= '0;
      end else if (defer_s) begin
         pend_valid_r <= 1'b1;
         pend_rank_r  <= ins_rank_s;
         pend_info_r  <= ins_info_s;
      end else begin
         pend_valid_r <= 1'b0;
      end
   end

   // Saturating count of full-chain inserts (both overwrites and discards).
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_drop_count <= 16'd0;
      end else if (drop_evt_s && (out_drop_count != 16'hFFFF)) begin
         out_drop_count <= out_drop_count + 16'd1;
      end else begin
         out_drop_count <= out_drop_count;
      end
   end
`else
   assign s_ins_ready = ~out_full;
   assign ins_acc_s   = s_ins_valid & s_ins_ready;
   assign ins_issue_s = ins_acc_s;
   assign cnt_inc_s   = ins_acc_s;
   assign ins_rank_s  = s_ins_rank;
   assign ins_info_s  = s_ins_info;
`endif

   // Occupancy moves at accept time so the ready outputs already account for in-flight ops.
   always_comb begin
      cnt_nxt_s = out_count;
      case ({cnt_inc_s, pop_acc_s})
         2'b10:   cnt_nxt_s = out_count + ONE_C;
         2'b01:   cnt_nxt_s = out_count - ONE_C;
         default: cnt_nxt_s = out_count;
      endcase
   end

   // Occupancy counter with registered full/empty flags.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_count <= ZERO_C;
         out_full  <= 1'b0;
         out_empty <= 1'b1;
      end else begin
         out_count <= cnt_nxt_s;
         out_full  <= (cnt_nxt_s == DEPTH_C);
         out_empty <= (cnt_nxt_s == ZERO_C);
      end
   end

   // Issue stage: broadcast element and chain controls, one cycle after accept.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_ctl_insert <= 1'b0;
         out_ctl_pop    <= 1'b0;
         out_pifo_input <= '0;
      end else begin
         out_ctl_insert <= ins_issue_s;
         out_ctl_pop    <= pop_acc_s;
         out_pifo_input <= ins_issue_s ? pack_element(ins_rank_s, ins_info_s) : '0;
      end
   end

   // The head is sampled in the pop-issue cycle, i.e. before that cycle's insert lands.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_deq_valid <= 1'b0;
         m_deq_rank  <= '0;
         m_deq_info  <= '0;
      end else if (out_ctl_pop) begin
         m_deq_valid <= 1'b1;
         m_deq_rank  <= in_pifo_head_element[RANK_END_POS:RANK_START_POS];
         m_deq_info  <= in_pifo_head_element[INFO_WIDTH-1:0];
      end else if (m_deq_valid && m_deq_ready) begin
         m_deq_valid <= 1'b0;
      end else begin
         m_deq_valid <= m_deq_valid;
      end
   end

endmodule
